led_pattern_seq: RTL and testbench

Parametrised LED pattern sequencer that plays an animation stored in an internal synchronous-read pattern RAM. It supports a configurable pattern width, memory depth and runtime sequence length, and three play modes: loop, one-shot and ping-pong. The RAM can be reloaded at runtime through a write port. The block sits between the Clockworks slow clock/tick domain and the board LEDs, and replaces fixed hard-wired pattern ROMs in SOC tops.

---
 rtl/led_pattern_seq.sv | 141 ++++++++++++++
 tb/tb_led_pattern_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: plays entries of an internal pattern RAM in loop,
// one-shot or ping-pong order, stepping one entry per tick while running.
module led_pattern_seq #(
  parameter int    WIDTH     = 8,
  parameter int    DEPTH     = 32,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    last,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] pattern,
  output logic [AW-1:0]    index,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0]    MODE_ONESHOT  = 2'd1;
  localparam logic [1:0]    MODE_PINGPONG = 2'd2;
  localparam logic [AW-1:0] LAST_MAX      = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    index_q, index_d;
  logic             dir_down_q, dir_down_d;
  logic [1:0]       mode_q, mode_d;
  logic [AW-1:0]    last_q, last_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    last_clamped;

  // Power-up contents only; reset never clears the RAM.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  // Write port is live in every state, including while reset is asserted.
  always @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign last_clamped = (32'(last) > 32'(DEPTH - 1)) ? LAST_MAX : last;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    dir_down_d = dir_down_q;
    mode_d     = mode_q;
    last_d     = last_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d    = RUN;
      index_d    = '0;
      dir_down_d = 1'b0;
      mode_d     = mode;
      last_d     = last_clamped;
    end else if (tick && state_q == RUN) begin
      if (mode_q == MODE_ONESHOT) begin
        if (index_q == last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          index_d = index_q + 1'b1;
        end
      end else if (mode_q == MODE_PINGPONG) begin
        // A single-entry sequence has nowhere to bounce to.
        if (last_q == '0) begin
          index_d = '0;
          wrap_d  = 1'b1;
        end else if (!dir_down_q) begin
          if (index_q == last_q) begin
            dir_down_d = 1'b1;
            index_d    = last_q - 1'b1;
            wrap_d     = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
          end
        end else begin
          if (index_q == '0) begin
            dir_down_d = 1'b0;
            index_d    = AW'(1);
            wrap_d     = 1'b1;
          end else begin
            index_d = index_q - 1'b1;
          end
        end
      end else begin
        if (index_q == last_q) begin
          index_d = '0;
          wrap_d  = 1'b1;
        end else begin
          index_d = index_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      index_q    <= '0;
      dir_down_q <= 1'b0;
      mode_q     <= '0;
      last_q     <= '0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      pattern_q  <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      dir_down_q <= dir_down_d;
      mode_q     <= mode_d;
      last_q     <= last_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      // Read-first: a same-cycle write to index_q is seen one read later.
      if (state_q == RUN) pattern_q <= mem_q[index_q];
    end
  end

  assign pattern = pattern_q;
  assign index   = index_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: loop, one-shot, ping-pong, full-depth
// wrap, stop/start priority, read-first RAM write and mid-run reset.
module tb_led_pattern_seq;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             resetn, tick, start, stop, we;
  logic [1:0]       mode;
  logic [AW-1:0]    last, waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] pattern;
  logic [AW-1:0]    index;
  logic             busy, done, wrap;

  int total = 0;
  int bad   = 0;

  led_pattern_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .start(start), .stop(stop),
    .mode(mode), .last(last), .we(we), .waddr(waddr), .wdata(wdata),
    .pattern(pattern), .index(index), .busy(busy), .done(done), .wrap(wrap)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic go(input logic [1:0] m, input logic [AW-1:0] l);
    start = 1'b1; mode = m; last = l;
    cyc();
    start = 1'b0;
  endtask

  // One tick, check its registered effects, then check the pulses clear.
  task automatic step(input string tag, input int e_idx, input bit e_wrap,
                      input bit e_done, input bit e_busy);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk({tag, ".index"}, 32'(index), 32'(e_idx));
    chk({tag, ".wrap"},  32'(wrap),  32'(e_wrap));
    chk({tag, ".done"},  32'(done),  32'(e_done));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    cyc();
    chk({tag, ".pulse_clr"}, {30'd0, wrap, done}, 32'd0);
  endtask

  logic [WIDTH-1:0] ram_exp [4];
  int pp_idx [7];

  initial begin
    ram_exp[0] = 8'h01; ram_exp[1] = 8'h02; ram_exp[2] = 8'h04; ram_exp[3] = 8'h08;
    pp_idx[0] = 1; pp_idx[1] = 2; pp_idx[2] = 3; pp_idx[3] = 2;
    pp_idx[4] = 1; pp_idx[5] = 0; pp_idx[6] = 1;
    resetn = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; we = 1'b0;
    mode = 2'd0; last = '0; waddr = '0; wdata = '0;
    cyc(); cyc();
    chk("rst.pattern", 32'(pattern), 32'h0);
    chk("rst.index",   32'(index),   32'h0);
    chk("rst.busy",    32'(busy),    32'h0);
    chk("rst.pulses",  {30'd0, wrap, done}, 32'h0);
    resetn = 1'b1;

    // 1: loop mode
    for (int i = 0; i < 4; i++) wr(AW'(i), ram_exp[i]);
    go(2'd0, 5'd3);
    chk("t1.busy_start", 32'(busy),  32'h1);
    chk("t1.idx_start",  32'(index), 32'h0);
    cyc();
    chk("t1.pat0", 32'(pattern), 32'h01);
    for (int k = 1; k <= 4; k++) begin
      step("t1", k % 4, k == 4, 1'b0, 1'b1);
      chk("t1.pat", 32'(pattern), 32'(ram_exp[k % 4]));
      cyc();
    end

    // 2: one-shot, restarted from RUN with no pulses
    go(2'd1, 5'd3);
    chk("t2.restart", {29'd0, busy, wrap, done}, 32'h4);
    chk("t2.idx0", 32'(index), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step("t2", k, 1'b0, 1'b0, 1'b1);
      chk("t2.pat", 32'(pattern), 32'(ram_exp[k]));
    end
    step("t2.end", 3, 1'b0, 1'b1, 1'b0);
    chk("t2.pat_end", 32'(pattern), 32'h08);
    step("t2.idle_tick", 3, 1'b0, 1'b0, 1'b0);
    step("t2.idle_tick2", 3, 1'b0, 1'b0, 1'b0);
    chk("t2.pat_hold", 32'(pattern), 32'h08);

    // 3: ping-pong
    go(2'd2, 5'd3);
    for (int k = 0; k < 7; k++) begin
      step("t3", pp_idx[k], (k == 3) || (k == 6), 1'b0, 1'b1);
      chk("t3.pat", 32'(pattern), 32'(ram_exp[pp_idx[k]]));
    end

    // 4: full-depth loop; last is AW bits so 31 is the largest request
    go(2'd0, 5'd31);
    for (int k = 1; k <= 32; k++) step("t4", k % 32, k == 32, 1'b0, 1'b1);

    // 5: stop beats start, then tick beside start is ignored
    go(2'd0, 5'd3);
    step("t5.a", 1, 1'b0, 1'b0, 1'b1);
    step("t5.b", 2, 1'b0, 1'b0, 1'b1);
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    chk("t5.stop_busy", 32'(busy),  32'h0);
    chk("t5.stop_idx",  32'(index), 32'h2);
    chk("t5.stop_done", 32'(done),  32'h0);
    cyc();
    chk("t5.hold_pat", 32'(pattern), 32'h04);
    start = 1'b1; tick = 1'b1; mode = 2'd0; last = 5'd3;
    cyc();
    start = 1'b0; tick = 1'b0;
    chk("t5.st_busy", 32'(busy),  32'h1);
    chk("t5.st_idx",  32'(index), 32'h0);

    // 6: read-first write at the playing index, then mid-run reset
    step("t6", 1, 1'b0, 1'b0, 1'b1);
    chk("t6.pat_old0", 32'(pattern), 32'h02);
    wr(5'd1, 8'hAA);
    chk("t6.pat_wrcyc", 32'(pattern), 32'h02);
    cyc();
    chk("t6.pat_new", 32'(pattern), 32'hAA);
    resetn = 1'b0; we = 1'b1; waddr = 5'd2; wdata = 8'h55;
    cyc();
    we = 1'b0;
    chk("t6.rst_pat",  32'(pattern), 32'h0);
    chk("t6.rst_idx",  32'(index),   32'h0);
    chk("t6.rst_busy", 32'(busy),    32'h0);
    resetn = 1'b1;
    go(2'd0, 5'd3);
    step("t6.r1", 1, 1'b0, 1'b0, 1'b1);
    chk("t6.ram_kept", 32'(pattern), 32'hAA);
    step("t6.r2", 2, 1'b0, 1'b0, 1'b1);
    chk("t6.wr_in_rst", 32'(pattern), 32'h55);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
